wb_led_walker: RTL and testbench

// Parametrised, bus-controlled LED walker: successor to the fixed 6-LED request walker.
// A Wishbone (pipelined, single-bit address) write starts a one-hot walk across NLEDS

---
 rtl/wb_led_walker_if.sv | 13 +
 rtl/wb_led_walker.sv | 89 ++++++++
 tb/tb_wb_led_walker.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_led_walker_if.sv
// wb_led_walker_if: pipelined Wishbone slave bus (single-bit address, 32-bit data)
interface wb_led_walker_if;
    logic        i_cyc;
    logic        i_stb;
    logic        i_we;
    logic        i_addr;
    logic [31:0] i_data;
    logic        o_stall;
    logic        o_ack;
    logic [31:0] o_data;
    modport master(output i_cyc, i_stb, i_we, i_addr, i_data, input o_stall, o_ack, o_data);
    modport slave(input i_cyc, i_stb, i_we, i_addr, i_data, output o_stall, o_ack, o_data);
endinterface

// File: rtl/wb_led_walker.sv
// wb_led_walker: Wishbone-controlled one-hot LED walker, bounce or wrap, programmable step period and repeats
module wb_led_walker #(
    parameter int NLEDS = 8,
    parameter int DW = 16,
    parameter logic [DW-1:0] DEFAULT_DIV = '0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    wb_led_walker_if.slave   bus,
    output logic [NLEDS-1:0] o_led
);
    localparam int PW = $clog2(NLEDS);
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
    state_t        r_state;
    logic [PW-1:0] r_pos;
    logic [DW-1:0] r_cnt;
    logic [DW-1:0] r_div;
    logic [7:0]    r_reps;
    logic          r_mode;
    logic          r_ack;
    logic [31:0]   r_data;
    logic          w_busy;
    logic          w_acc;
    logic          w_ctrl_wr;
    logic          w_abort;
    logic          w_start;
    assign w_busy    = r_state != IDLE;
    assign bus.o_stall = w_busy && bus.i_we && !bus.i_addr && !bus.i_data[31];
    assign w_acc     = bus.i_cyc && bus.i_stb && !bus.o_stall;
    assign w_ctrl_wr = w_acc && bus.i_we && !bus.i_addr;
    assign w_abort   = w_ctrl_wr && bus.i_data[31];
    // a start can only be accepted while idle because CTRL starts stall when busy
    assign w_start   = w_ctrl_wr && !bus.i_data[31];
    assign bus.o_ack  = r_ack;
    assign bus.o_data = r_data;
    assign o_led      = w_busy ? NLEDS'(1) << r_pos : '0;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_pos   <= '0;
            r_cnt   <= '0;
            r_div   <= DEFAULT_DIV;
            r_reps  <= '0;
            r_mode  <= 1'b0;
            r_ack   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_ack <= w_acc;
            if (w_acc)
                r_data <= bus.i_we ? 32'd0 : bus.i_addr ? 32'(r_div) :
                          {w_busy, 14'b0, r_mode, r_reps, 8'(r_pos)};
            if (w_acc && bus.i_we && bus.i_addr)
                r_div <= bus.i_data[DW-1:0];
            if (w_abort) begin
                r_state <= IDLE;
                r_pos   <= '0;
                r_cnt   <= '0;
            end else if (w_start) begin
                r_state <= UP;
                r_pos   <= '0;
                r_cnt   <= '0;
                r_reps  <= bus.i_data[15:8];
                r_mode  <= bus.i_data[0];
            end else if (w_busy) begin
                // >= so that shrinking DIV below the running count still steps at once
                if (r_cnt >= r_div) begin
                    r_cnt <= '0;
                    if (r_state == UP && r_pos < PW'(NLEDS - 1)) begin
                        r_pos <= r_pos + 1'b1;
                    end else if (r_state == UP && !r_mode) begin
                        r_state <= DOWN;
                        r_pos   <= r_pos - 1'b1;
                    end else if (r_state == DOWN && r_pos != '0) begin
                        r_pos <= r_pos - 1'b1;
                    end else if (r_reps != '0) begin
                        r_reps  <= r_reps - 1'b1;
                        r_pos   <= '0;
                        r_state <= UP;
                    end else begin
                        r_state <= IDLE;
                        r_pos   <= '0;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_led_walker.sv
// tb_wb_led_walker: directed and randomized checks of wb_led_walker against a sequence model
module tb_wb_led_walker;
    localparam int N = 8;
    localparam int DW = 16;
    localparam logic [DW-1:0] DEF = 16'h0;
    logic         i_clk = 1'b0;
    logic         i_reset_n = 1'b0;
    logic [N-1:0] o_led;
    wb_led_walker_if bus();
    wb_led_walker #(.NLEDS(N), .DW(DW), .DEFAULT_DIV(DEF)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(bus), .o_led(o_led));
    always #5 i_clk = ~i_clk;
    int checks = 0;
    int errors = 0;
    int seq[$];
    int idx;
    int plen;
    int cur_r;
    logic cur_mode;
    logic [31:0] rd;
    int st;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // expected LED position for every busy cycle, each held div+1 clocks
    function automatic void build(input logic mode, input int r, input int div);
        seq.delete();
        cur_mode = mode;
        cur_r = r;
        plen = (mode ? N : 2 * N - 1) * (div + 1);
        for (int p = 0; p <= r; p++) begin
            for (int k = 0; k < N; k++) repeat (div + 1) seq.push_back(k);
            if (!mode) for (int k = N - 2; k >= 0; k--) repeat (div + 1) seq.push_back(k);
        end
    endfunction

    function automatic logic [31:0] exp_led(input int j);
        return (j >= 0 && j < seq.size()) ? 32'(1) << seq[j] : 32'd0;
    endfunction

    function automatic logic [31:0] exp_ctrl(input int j);
        logic b;
        int reps, pos;
        b = j < seq.size();
        reps = b ? cur_r - j / plen : 0;
        pos = b ? seq[j] : 0;
        return {b, 14'b0, cur_mode, 8'(reps), 8'(pos)};
    endfunction

    task automatic led_now();
        chk("led", 32'(o_led), exp_led(idx));
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(negedge i_clk);
            idx++;
            chk("led", 32'(o_led), exp_led(idx));
            chk("ack_idle", 32'(bus.o_ack), 32'd0);
        end
    endtask

    // called at a negedge; returns at the negedge of the ack cycle
    task automatic bus_op(input logic we, input logic addr, input logic [31:0] d,
                          output logic [31:0] rdata, output int stalls);
        bus.i_cyc = 1'b1;
        bus.i_stb = 1'b1;
        bus.i_we = we;
        bus.i_addr = addr;
        bus.i_data = d;
        stalls = 0;
        #1;
        while (bus.o_stall && stalls < 2000) begin
            @(negedge i_clk);
            #1;
            stalls++;
        end
        if (stalls >= 2000) chk("stall_bound", 32'(stalls), 32'd0);
        @(posedge i_clk);
        #1;
        bus.i_cyc = 1'b0;
        bus.i_stb = 1'b0;
        bus.i_we = 1'b0;
        @(negedge i_clk);
        chk("ack", 32'(bus.o_ack), 32'd1);
        rdata = bus.o_data;
        idx++;
    endtask

    task automatic step_chk(input int n, input logic [31:0] exp);
        repeat (n) @(negedge i_clk);
        chk("led_div", 32'(o_led), exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_cyc = 1'b0;
        bus.i_stb = 1'b0;
        bus.i_we = 1'b0;
        bus.i_addr = 1'b0;
        bus.i_data = '0;
        seq.delete();
        idx = 0;
        #23 i_reset_n = 1'b1;
        @(negedge i_clk);
        chk("rst_led", 32'(o_led), 32'd0);
        chk("rst_ack", 32'(bus.o_ack), 32'd0);
        chk("rst_data", bus.o_data, 32'd0);
        bus_op(1'b0, 1'b1, 32'd0, rd, st);
        chk("rst_div", rd, 32'(DEF));
        chk("read_nostall", 32'(st), 32'd0);
        bus_op(1'b0, 1'b0, 32'd0, rd, st);
        chk("rst_ctrl", rd, 32'd0);
        // bounce, DIV=0, single pass
        build(1'b0, 0, 0);
        idx = -1;
        bus_op(1'b1, 1'b0, 32'h0, rd, st);
        chk("wr_data", rd, 32'd0);
        led_now();
        adv(15);
        // wrap, DIV=1, R=2 with mid-walk reads
        bus_op(1'b1, 1'b1, 32'd1, rd, st);
        build(1'b1, 2, 1);
        idx = -1;
        bus_op(1'b1, 1'b0, 32'h0201, rd, st);
        led_now();
        for (int k = 0; k < 3; k++) begin
            adv(k == 0 ? 3 : 16);
            bus_op(1'b0, 1'b0, 32'd0, rd, st);
            chk("ctrl_mid", rd, exp_ctrl(idx - 1));
            chk("reps_mid", 32'(rd[15:8]), 32'(2 - k));
            led_now();
        end
        adv(10);
        chk("wrap_len", 32'(idx), 32'd48);
        // randomized walks against the sequence model
        for (int it = 0; it < 8; it++) begin
            int div, r;
            logic mode;
            div = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            mode = 1'($urandom_range(0, 1));
            bus_op(1'b1, 1'b1, 32'(div), rd, st);
            bus_op(1'b0, 1'b1, 32'd0, rd, st);
            chk("div_rb", rd, 32'(div));
            build(mode, r, div);
            idx = -1;
            bus_op(1'b1, 1'b0, {16'h0, 8'(r), 7'h0, mode}, rd, st);
            led_now();
            while (idx < seq.size()) begin
                adv($urandom_range(1, 6));
                if ($urandom_range(0, 1) == 1) begin
                    bus_op(1'b0, 1'b0, 32'd0, rd, st);
                    chk("rnd_ctrl", rd, exp_ctrl(idx - 1));
                    chk("rnd_nostall", 32'(st), 32'd0);
                    led_now();
                end
            end
            adv(1);
        end
        // CTRL write while busy stalls until idle; reads do not stall
        bus_op(1'b1, 1'b1, 32'd0, rd, st);
        build(1'b0, 0, 0);
        idx = -1;
        bus_op(1'b1, 1'b0, 32'h0, rd, st);
        led_now();
        bus_op(1'b0, 1'b0, 32'd0, rd, st);
        chk("busy_read_stall", 32'(st), 32'd0);
        chk("busy_read", rd, exp_ctrl(idx - 1));
        begin
            int expst;
            expst = seq.size() - idx;
            bus_op(1'b1, 1'b0, 32'h1, rd, st);
            chk("stall_cycles", 32'(st), 32'(expst));
        end
        build(1'b1, 0, 0);
        idx = 0;
        led_now();
        adv(8);
        // abort mid-walk
        bus_op(1'b1, 1'b1, 32'd2, rd, st);
        build(1'b0, 3, 2);
        idx = -1;
        bus_op(1'b1, 1'b0, 32'h0300, rd, st);
        led_now();
        adv(5);
        bus_op(1'b1, 1'b0, 32'h8000_0000, rd, st);
        chk("abort_stall", 32'(st), 32'd0);
        chk("abort_led", 32'(o_led), 32'd0);
        bus_op(1'b0, 1'b0, 32'd0, rd, st);
        chk("abort_busy", 32'(rd[31]), 32'd0);
        // DIV shrink below the running count steps on the following cycle
        bus_op(1'b1, 1'b1, 32'hF0, rd, st);
        bus_op(1'b1, 1'b0, 32'h0, rd, st);
        chk("div_start", 32'(o_led), 32'h01);
        step_chk(32, 32'h01);
        bus_op(1'b1, 1'b1, 32'h10, rd, st);
        chk("div_wr_led", 32'(o_led), 32'h01);
        step_chk(1, 32'h02);
        step_chk(16, 32'h02);
        step_chk(1, 32'h04);
        step_chk(17, 32'h08);
        // asynchronous reset mid-walk
        build(1'b0, 1, 16);
        idx = -1;
        bus_op(1'b1, 1'b0, 32'h0100, rd, st);
        led_now();
        adv(20);
        bus_op(1'b0, 1'b0, 32'd0, rd, st);
        chk("pre_rst_data", rd, exp_ctrl(idx - 1));
        #2 i_reset_n = 1'b0;
        #1;
        chk("arst_led", 32'(o_led), 32'd0);
        chk("arst_ack", 32'(bus.o_ack), 32'd0);
        chk("arst_data", bus.o_data, 32'd0);
        @(posedge i_clk);
        #3 i_reset_n = 1'b1;
        @(negedge i_clk);
        bus_op(1'b0, 1'b1, 32'd0, rd, st);
        chk("arst_div", rd, 32'(DEF));
        chk("arst_idle_led", 32'(o_led), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
